game_status_tracker: RTL

GAME_STATUS_TRACKER -- requirements
Module: game_status_tracker

---
 rtl/game_pkg.sv | 40 ++++
 rtl/frame_countdown.sv | 42 ++++
 rtl/game_status_tracker.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game status tracker: the tracker state encoding,
// field widths of the status outputs, the score ceiling and a saturating
// score adder.
// ----------------------------------------------------------------------------
package game_pkg;

    // Tracker state encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAYING  = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // Field widths of the status outputs and the cooldown counter
    localparam int LIVES_W    = 2;
    localparam int INVADERS_W = 6;
    localparam int SCORE_W    = 14;
    localparam int FRAME_W    = 8;

    // Score ceiling (fits a four-digit decimal display)
    localparam logic [SCORE_W-1:0] MAX_SCORE = 14'd9999;

    // Add two scores and clamp the result at MAX_SCORE
    function automatic logic [SCORE_W-1:0] sat_add_score(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, MAX_SCORE}) begin
            return MAX_SCORE;
        end else begin
            return sum[SCORE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/frame_countdown.sv
// ----------------------------------------------------------------------------
// frame_countdown
// Loadable down-counter used to time the invulnerability window after a hit.
// A load wins over a tick; a tick at zero leaves the counter at zero.
//
// Ports:
//   clk          : system clock, all logic on posedge
//   reset        : synchronous active-high reset, clears the counter
//   i_load       : load i_load_value into the counter
//   i_load_value : value to load
//   i_tick       : decrement request (one per frame while counting)
//   o_zero       : counter currently holds zero
// ----------------------------------------------------------------------------
module frame_countdown #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_tick,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Counter register: reset, load, or decrement toward zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_tick && (r_count != {WIDTH{1'b0}})) begin
            r_count <= r_count - WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {WIDTH{1'b0}});

endmodule

// File: rtl/game_status_tracker.sv
// ----------------------------------------------------------------------------
// game_status_tracker
// Tracks lives, remaining invaders, score and game-over status for one game.
// States: IDLE -> PLAYING <-> COOLDOWN -> DONE; start restarts from any state.
// All status outputs are registered, so game over is visible on the clock
// edge that samples the causing event.
//
// Optional feature: define HIGH_SCORE_EN to add the high_score output, which
// keeps the best final score across games and is cleared only by reset.
//
// Ports:
//   clk            : system clock
//   reset          : synchronous active-high reset, overrides everything
//   start          : pulse, begins a new game (highest priority after reset)
//   is_playing     : level, events are counted only while high
//   frame_tick     : pulse once per video frame (cooldown timing)
//   player_hit     : pulse, bullet hit the player
//   invader_killed : pulse, one invader destroyed
//   invader_landed : level, an invader reached the player row
//   finished       : registered, game over
//   win            : registered, valid with finished; 1 = all invaders cleared
//   lives          : remaining lives
//   invaders_left  : remaining invaders
//   score          : binary score, saturating at MAX_SCORE
//   invulnerable   : high while in the post-hit cooldown
//   high_score     : (HIGH_SCORE_EN only) best final score since reset
// ----------------------------------------------------------------------------
module game_status_tracker
    import game_pkg::*;
#(
    parameter int INIT_LIVES      = 3,
    parameter int NUM_INVADERS    = 55,
    parameter int COOLDOWN_FRAMES = 60,
    parameter int POINTS_PER_KILL = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_playing,
    input  logic                  frame_tick,
    input  logic                  player_hit,
    input  logic                  invader_killed,
    input  logic                  invader_landed,
    output logic                  finished,
    output logic                  win,
    output logic [LIVES_W-1:0]    lives,
    output logic [INVADERS_W-1:0] invaders_left,
    output logic [SCORE_W-1:0]    score,
    output logic                  invulnerable
`ifdef HIGH_SCORE_EN
    ,
    output logic [SCORE_W-1:0]    high_score
`endif
);

    state_e                r_state;
    logic [LIVES_W-1:0]    r_lives;
    logic [INVADERS_W-1:0] r_invaders;
    logic [SCORE_W-1:0]    r_score;
    logic                  r_finished;
    logic                  r_win;
    logic                  r_invul;

    state_e                w_state_next;
    logic [LIVES_W-1:0]    w_lives_next;
    logic [INVADERS_W-1:0] w_invaders_next;
    logic [SCORE_W-1:0]    w_score_next;
    logic                  w_finished_next;
    logic                  w_win_next;
    logic                  w_cd_load;
    logic [FRAME_W-1:0]    w_cd_value;
    logic                  w_cd_tick;
    logic                  w_cd_zero;
    logic                  w_hit_taken;

    // Cooldown timer: loaded on a non-lethal hit, ticks only while counting
    frame_countdown #(
        .WIDTH (FRAME_W)
    ) u_frame_countdown (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_cd_load),
        .i_load_value (w_cd_value),
        .i_tick       (w_cd_tick),
        .o_zero       (w_cd_zero)
    );

    // Next-state and next-status computation
    always_comb begin
        w_state_next    = r_state;
        w_lives_next    = r_lives;
        w_invaders_next = r_invaders;
        w_score_next    = r_score;
        w_finished_next = r_finished;
        w_win_next      = r_win;
        w_cd_load       = 1'b0;
        w_cd_value      = {FRAME_W{1'b0}};
        w_cd_tick       = 1'b0;
        w_hit_taken     = 1'b0;

        if (start) begin
            // New game: reload everything and clear the cooldown timer
            w_state_next    = ST_PLAYING;
            w_lives_next    = LIVES_W'(INIT_LIVES);
            w_invaders_next = INVADERS_W'(NUM_INVADERS);
            w_score_next    = {SCORE_W{1'b0}};
            w_finished_next = 1'b0;
            w_win_next      = 1'b0;
            w_cd_load       = 1'b1;
            w_cd_value      = {FRAME_W{1'b0}};
        end else begin
            case (r_state)
                ST_PLAYING, ST_COOLDOWN: begin
                    if (is_playing) begin
                        w_cd_tick   = (r_state == ST_COOLDOWN) && frame_tick;
                        w_hit_taken = (r_state == ST_PLAYING) && player_hit;

                        // Kills count in both active states, even on a lethal hit
                        if (invader_killed) begin
                            if (r_invaders != {INVADERS_W{1'b0}}) begin
                                w_invaders_next = r_invaders - INVADERS_W'(1);
                            end else begin
                                w_invaders_next = r_invaders;
                            end
                            w_score_next = sat_add_score(r_score, SCORE_W'(POINTS_PER_KILL));
                        end else begin
                            w_invaders_next = r_invaders;
                        end

                        if (w_hit_taken && (r_lives != {LIVES_W{1'b0}})) begin
                            w_lives_next = r_lives - LIVES_W'(1);
                        end else begin
                            w_lives_next = r_lives;
                        end

                        // Loss outranks a simultaneous win
                        if (invader_landed || (w_hit_taken && (w_lives_next == {LIVES_W{1'b0}}))) begin
                            w_state_next    = ST_DONE;
                            w_finished_next = 1'b1;
                            w_win_next      = 1'b0;
                        end else if (invader_killed && (w_invaders_next == {INVADERS_W{1'b0}})) begin
                            w_state_next    = ST_DONE;
                            w_finished_next = 1'b1;
                            w_win_next      = 1'b1;
                        end else if (w_hit_taken) begin
                            w_state_next = ST_COOLDOWN;
                            w_cd_load    = 1'b1;
                            w_cd_value   = FRAME_W'(COOLDOWN_FRAMES);
                        end else if ((r_state == ST_COOLDOWN) && w_cd_zero) begin
                            w_state_next = ST_PLAYING;
                        end else begin
                            w_state_next = r_state;
                        end
                    end else if ((r_state == ST_COOLDOWN) && w_cd_zero) begin
                        // Timer already expired: leave cooldown even while paused
                        w_state_next = ST_PLAYING;
                    end else begin
                        w_state_next = r_state;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    w_state_next = r_state;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_lives    <= {LIVES_W{1'b0}};
            r_invaders <= {INVADERS_W{1'b0}};
            r_score    <= {SCORE_W{1'b0}};
            r_finished <= 1'b0;
            r_win      <= 1'b0;
            r_invul    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_lives    <= w_lives_next;
            r_invaders <= w_invaders_next;
            r_score    <= w_score_next;
            r_finished <= w_finished_next;
            r_win      <= w_win_next;
            r_invul    <= (w_state_next == ST_COOLDOWN);
        end
    end

    assign finished      = r_finished;
    assign win           = r_win;
    assign lives         = r_lives;
    assign invaders_left = r_invaders;
    assign score         = r_score;
    assign invulnerable  = r_invul;

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] r_high_score;

    // Best final score, captured on the transition into DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_high_score <= {SCORE_W{1'b0}};
        end else if ((r_state != ST_DONE) && (w_state_next == ST_DONE)
                     && (w_score_next > r_high_score)) begin
            r_high_score <= w_score_next;
        end else begin
            r_high_score <= r_high_score;
        end
    end

    assign high_score = r_high_score;
`endif

endmodule
